// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding, requester ids, read latency bounds.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  localparam logic ID_CORE = 1'b0;
  localparam logic ID_LDR  = 1'b1;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-requester grant picker: round-robin against the last grant, or fixed loader priority.
// Purely combinational; the result is only meaningful when at least one request is set.
module mem_arb_rr2
  import mem_arb_pkg::*;
(
  input  logic req_core,
  input  logic req_ldr,
  input  logic ptr,
  input  logic rr_enable,
  output logic grant_id
);

  always_comb begin
    grant_id = ID_LDR;
    if (req_core && req_ldr) begin
      // ptr holds the last winner, so the other requester goes next
      grant_id = rr_enable ? ~ptr : ID_LDR;
    end else if (req_core) begin
      grant_id = ID_CORE;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Arbitrates a core port and a loader port onto one single-ported memory, one transaction at a time.
// Write ack 2 cycles after the request is sampled in IDLE, read ack 2+RD_LATENCY; requests wait until the arbiter is idle.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int RR_ENABLE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [15:0] core_addr,
  input  logic [7:0]  core_wdata,
  output logic [7:0]  core_rdata,
  output logic        core_ack,
  input  logic        ldr_req,
  input  logic        ldr_we,
  input  logic [15:0] ldr_addr,
  input  logic [7:0]  ldr_wdata,
  output logic [7:0]  ldr_rdata,
  output logic        ldr_ack,
  input  logic        ldr_lock,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        busy
);

  state_t      state, state_nxt;
  logic        core_elig, any_elig, grant_id;
  logic        lat_id, lat_we;
  logic [15:0] lat_addr;
  logic [7:0]  lat_wdata;
  logic [1:0]  wait_cnt;
  logic        wait_last;
  logic        rr_ptr;

  assign core_elig = core_req & ~ldr_lock;
  assign any_elig  = core_elig | ldr_req;
  assign wait_last = (wait_cnt == 2'(RD_LATENCY - 1));

  mem_arb_rr2 u_rr2 (
    .req_core  (core_elig),
    .req_ldr   (ldr_req),
    .ptr       (rr_ptr),
    .rr_enable (RR_ENABLE != 0),
    .grant_id  (grant_id)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (any_elig) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = lat_we ? ST_ACK : ST_WAIT;
      ST_WAIT:  if (wait_last) state_nxt = ST_ACK;
      ST_ACK:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_en   = (state == ST_ISSUE);
    mem_we   = (state == ST_ISSUE) & lat_we;
    busy     = (state != ST_IDLE);
    core_ack = (state == ST_ACK) & (lat_id == ID_CORE);
    ldr_ack  = (state == ST_ACK) & (lat_id == ID_LDR);
  end

  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  // Reset favours the loader by recording the core as the last winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_id     <= ID_CORE;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      wait_cnt   <= '0;
      rr_ptr     <= ID_CORE;
      core_rdata <= '0;
      ldr_rdata  <= '0;
    end else begin
      if (state == ST_IDLE && any_elig) begin
        lat_id    <= grant_id;
        rr_ptr    <= grant_id;
        lat_we    <= (grant_id == ID_LDR) ? ldr_we    : core_we;
        lat_addr  <= (grant_id == ID_LDR) ? ldr_addr  : core_addr;
        lat_wdata <= (grant_id == ID_LDR) ? ldr_wdata : core_wdata;
      end
      if (state == ST_WAIT) begin
        if (wait_last) begin
          wait_cnt <= '0;
          if (lat_id == ID_LDR) ldr_rdata  <= mem_rdata;
          else                  core_rdata <= mem_rdata;
        end else begin
          wait_cnt <= wait_cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with RD_LATENCY=2, round-robin enabled, and a latency-accurate memory model.
module tb_mem_arb;

  localparam int RDL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we, core_ack;
  logic [15:0] core_addr;
  logic [7:0]  core_wdata, core_rdata;
  logic        ldr_req, ldr_we, ldr_ack, ldr_lock;
  logic [15:0] ldr_addr;
  logic [7:0]  ldr_wdata, ldr_rdata;
  logic        mem_en, mem_we, busy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arb #(.RD_LATENCY(RDL), .RR_ENABLE(1)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_ack(core_ack),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr),
    .ldr_wdata(ldr_wdata), .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
    .ldr_lock(ldr_lock),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory model: read data appears exactly RDL cycles after mem_en, 0xEE otherwise.
  bit         wr_seen [0:65535];
  logic [7:0] mem     [0:65535];
  logic [7:0] rd_pipe [0:3];

  function logic [7:0] mem_model_rd(input logic [15:0] a);
    if (wr_seen[a])        return mem[a];
    else if (a == 16'h0150) return 8'hC3;
    else                   return a[7:0] ^ 8'h3C;
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem[mem_addr]     <= mem_wdata;
      wr_seen[mem_addr] <= 1'b1;
    end
    rd_pipe[0] <= (mem_en && !mem_we) ? mem_model_rd(mem_addr) : 8'hEE;
    for (int i = 1; i < 4; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign mem_rdata = rd_pipe[RDL-1];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
    ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0; ldr_lock = 0;
    tick; tick;
    checks++;
    if ({core_ack, ldr_ack, mem_en, mem_we, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got core_ack,ldr_ack,mem_en,mem_we,busy=%b required 00000",
               {core_ack, ldr_ack, mem_en, mem_we, busy});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 24'h0) begin
      errors++;
      $display("FAIL reset_mem_bus: got addr=%h wdata=%h required 0000/00", mem_addr, mem_wdata);
    end
    checks++;
    if ({core_rdata, ldr_rdata} !== 16'h0) begin
      errors++;
      $display("FAIL reset_rdata: got core=%h ldr=%h required 00/00", core_rdata, ldr_rdata);
    end
    rst = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_core_read;
    int en_cnt = 0, en_cyc = -1, ack_cyc = -1;
    logic [15:0] addr_at_en = '0;
    logic        we_at_en = 1'b1;
    logic [7:0]  rd_at_ack = '0;
    core_req = 1; core_we = 0; core_addr = 16'h0150;
    for (int c = 1; c <= 10; c++) begin
      tick;
      if (mem_en) begin
        en_cnt++;
        if (en_cyc < 0) begin en_cyc = c; addr_at_en = mem_addr; we_at_en = mem_we; end
      end
      if (core_ack && ack_cyc < 0) begin
        ack_cyc = c; rd_at_ack = core_rdata; core_req = 0;
      end
    end
    checks++;
    if (en_cnt !== 1 || en_cyc !== 1) begin
      errors++;
      $display("FAIL core_rd_mem_en: got count=%0d first_cycle=%0d required 1/1", en_cnt, en_cyc);
    end
    checks++;
    if (addr_at_en !== 16'h0150 || we_at_en !== 1'b0) begin
      errors++;
      $display("FAIL core_rd_addr: got addr=%h we=%b required 0150/0", addr_at_en, we_at_en);
    end
    checks++;
    if (ack_cyc !== 4) begin
      errors++;
      $display("FAIL core_rd_ack_cycle: got %0d required 4", ack_cyc);
    end
    checks++;
    if (rd_at_ack !== 8'hC3) begin
      errors++;
      $display("FAIL core_rd_data: got %h required c3", rd_at_ack);
    end
  endtask

  task automatic test_ldr_write;
    int ack_cyc = -1, ack_cnt = 0, core_acks = 0;
    logic [25:0] bus_c1 = '0;
    ldr_req = 1; ldr_we = 1; ldr_addr = 16'h8000; ldr_wdata = 8'h5A;
    for (int c = 1; c <= 8; c++) begin
      tick;
      if (c == 1) begin
        bus_c1 = {mem_en, mem_we, mem_addr, mem_wdata};
        ldr_req = 0;  // dropped early: the transaction must still finish
      end
      if (ldr_ack) begin ack_cnt++; if (ack_cyc < 0) ack_cyc = c; end
      if (core_ack) core_acks++;
    end
    checks++;
    if (bus_c1 !== {1'b1, 1'b1, 16'h8000, 8'h5A}) begin
      errors++;
      $display("FAIL ldr_wr_bus: got en,we,addr,wdata=%h required %h", bus_c1,
               {1'b1, 1'b1, 16'h8000, 8'h5A});
    end
    checks++;
    if (ack_cyc !== 2 || ack_cnt !== 1) begin
      errors++;
      $display("FAIL ldr_wr_ack: got cycle=%0d pulses=%0d required 2/1", ack_cyc, ack_cnt);
    end
    checks++;
    if (core_acks !== 0) begin
      errors++;
      $display("FAIL ldr_wr_no_core_ack: got %0d required 0", core_acks);
    end
    checks++;
    if (core_rdata !== 8'hC3) begin
      errors++;
      $display("FAIL core_rdata_hold: got %h required c3", core_rdata);
    end
  endtask

  task automatic test_round_robin;
    int seq [8];
    int ack_at [8];
    int n = 0, core_n = 0, ldr_n = 0, both = 0;
    rst = 1; tick; rst = 0; tick;
    core_req = 1; core_we = 0; core_addr = 16'h0150;
    ldr_req = 1; ldr_we = 0; ldr_addr = 16'h8000;
    for (int c = 1; c <= 60 && n < 8; c++) begin
      tick;
      if (core_ack && ldr_ack) both++;
      if (core_ack || ldr_ack) begin
        seq[n] = ldr_ack ? 1 : 0;
        ack_at[n] = c;
        if (ldr_ack) ldr_n++; else core_n++;
        n++;
        if (n == 8) begin core_req = 0; ldr_req = 0; end
      end
    end
    core_req = 0; ldr_req = 0;
    checks++;
    if (n !== 8 || both !== 0) begin
      errors++;
      $display("FAIL rr_tx_count: got acks=%0d simultaneous=%0d required 8/0", n, both);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (seq[k] !== ((k % 2 == 0) ? 1 : 0) || ack_at[k] !== 4 + 5 * k) begin
        errors++;
        $display("FAIL rr_grant_%0d: got id=%0d cycle=%0d required id=%0d cycle=%0d",
                 k, seq[k], ack_at[k], (k % 2 == 0) ? 1 : 0, 4 + 5 * k);
      end
    end
    checks++;
    if (core_n !== 4 || ldr_n !== 4) begin
      errors++;
      $display("FAIL rr_balance: got core=%0d ldr=%0d required 4/4", core_n, ldr_n);
    end
    checks++;
    if (core_rdata !== 8'hC3 || ldr_rdata !== 8'h5A) begin
      errors++;
      $display("FAIL rr_rdata: got core=%h ldr=%h required c3/5a", core_rdata, ldr_rdata);
    end
    tick; tick;
  endtask

  task automatic test_lock;
    int activity = 0, ack_cyc = -1;
    logic en_c1, busy_c1;
    logic [15:0] addr_c1;
    ldr_lock = 1; core_req = 1; core_we = 0; core_addr = 16'h0150;
    for (int c = 1; c <= 20; c++) begin
      tick;
      if (mem_en || core_ack || busy) activity++;
    end
    checks++;
    if (activity !== 0) begin
      errors++;
      $display("FAIL lock_blocks_core: got %0d active cycles required 0", activity);
    end
    ldr_lock = 0;
    tick;
    en_c1 = mem_en; busy_c1 = busy; addr_c1 = mem_addr;
    checks++;
    if (en_c1 !== 1'b1 || busy_c1 !== 1'b1 || addr_c1 !== 16'h0150) begin
      errors++;
      $display("FAIL unlock_grant: got en=%b busy=%b addr=%h required 1/1/0150",
               en_c1, busy_c1, addr_c1);
    end
    for (int c = 2; c <= 8; c++) begin
      tick;
      if (core_ack && ack_cyc < 0) begin ack_cyc = c; core_req = 0; end
    end
    checks++;
    if (ack_cyc !== 4) begin
      errors++;
      $display("FAIL unlock_ack_cycle: got %0d required 4", ack_cyc);
    end
  endtask

  task automatic test_lock_midflight;
    int core_ack_cyc = -1, ldr_ack_cyc = -1;
    core_req = 1; core_we = 0; core_addr = 16'h0150;
    for (int c = 1; c <= 14; c++) begin
      tick;
      if (c == 2) begin
        ldr_lock = 1; ldr_req = 1; ldr_we = 0; ldr_addr = 16'h8000;
      end
      if (core_ack && core_ack_cyc < 0) begin core_ack_cyc = c; core_req = 0; end
      if (ldr_ack && ldr_ack_cyc < 0) begin ldr_ack_cyc = c; ldr_req = 0; end
    end
    ldr_lock = 0;
    checks++;
    if (core_ack_cyc !== 4) begin
      errors++;
      $display("FAIL lock_midflight_core_ack: got cycle %0d required 4", core_ack_cyc);
    end
    checks++;
    if (ldr_ack_cyc !== 9 || ldr_rdata !== 8'h5A) begin
      errors++;
      $display("FAIL lock_midflight_ldr: got cycle=%0d data=%h required 9/5a", ldr_ack_cyc, ldr_rdata);
    end
  endtask

  task automatic test_rst_in_wait;
    int stray = 0, ack_cyc = -1;
    core_req = 1; core_we = 0; core_addr = 16'h0150;
    tick; tick;
    rst = 1; core_req = 0;
    tick;
    checks++;
    if ({core_ack, mem_en, busy} !== 3'b000 || core_rdata !== 8'h00) begin
      errors++;
      $display("FAIL rst_in_wait: got ack,en,busy=%b rdata=%h required 000/00",
               {core_ack, mem_en, busy}, core_rdata);
    end
    rst = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (core_ack || busy) stray++;
    end
    checks++;
    if (stray !== 0 || core_rdata !== 8'h00) begin
      errors++;
      $display("FAIL rst_abandon: got stray=%0d rdata=%h required 0/00", stray, core_rdata);
    end
    ldr_req = 1; ldr_we = 0; ldr_addr = 16'h8000;
    for (int c = 1; c <= 8; c++) begin
      tick;
      if (ldr_ack && ack_cyc < 0) begin ack_cyc = c; ldr_req = 0; end
    end
    checks++;
    if (ack_cyc !== 4 || ldr_rdata !== 8'h5A) begin
      errors++;
      $display("FAIL post_rst_ldr_read: got cycle=%0d data=%h required 4/5a", ack_cyc, ldr_rdata);
    end
  endtask

  initial begin
    test_reset;
    test_core_read;
    test_ldr_write;
    test_round_robin;
    test_lock;
    test_lock_midflight;
    test_rst_in_wait;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
